config_loader: RTL and testbench
================================

// Module: config_loader
// PURPOSE
// - Upstream stage of the tile array's configuration bus. Takes a byte-serial bitstream from the
//   host/boot interface and assembles each 8-byte record into a 32-bit address and 32-bit data word.
// - Broadcasts each record to every tile's config_addr/config_data for a fixed hold window, then
//   returns the bus to a non-matching idle address.
// - Tile address matchers decode tile_id in addr[15:0] and the module flag in addr[31:16].
// PARAMETERS
// - HOLD_CYCLES  default 2             cycles a record is driven on the bus; legal range >=1
// - GAP_CYCLES   default 1             idle-address cycles after each record; legal range >=1
// - IDLE_ADDR    default 32'h0000_0000 bus address when not writing; flag 0 matches no tile module
// - EOS_ADDR     default 32'hFFFF_FFFF end-of-stream marker; never driven onto the bus
// PORTS
// - clk          in   1   clock
// - reset        in   1   asynchronous, active-low reset
// - start        in   1   one-cycle pulse; arms the loader and clears done/count
// - in_byte      in   8   bitstream byte
// - in_valid     in   1   in_byte valid
// - in_ready     out  1   loader accepts in_byte this cycle (transfer = in_valid & in_ready)
// - config_addr  out  32  broadcast configuration address
// - config_data  out  32  broadcast configuration data
// - busy         out  1   armed and not done
// - done         out  1   EOS record received; sticky until start or reset
// - word_count   out  16  records broadcast since last start; saturates at 16'hFFFF
// BEHAVIOUR
// Reset values
// - reset low (async): config_addr=IDLE_ADDR, config_data=0, in_ready=0, busy=0, done=0,
//   word_count=0, state=OFF.
// Record format
// - Bytes 0-3 form the address; bytes 4-7 form the data. Both fields are little-endian, so
//   byte 0 lands in addr[7:0].
// State OFF
// - in_ready=0.
// - start -> LOAD: byte_cnt=0, word_count=0, done=0.
// State LOAD
// - in_ready=1.
// - Each transfer writes the byte into the shift/assembly register and increments the 3-bit byte_cnt.
// - The 8th transfer (byte_cnt==7) completes the record:
//   - addr==EOS_ADDR -> DONE.
//   - otherwise -> DRIVE with hold_cnt=HOLD_CYCLES-1.
// - in_valid low stalls indefinitely. There is no timeout.
// State DRIVE
// - In_ready=0. config_addr/config_data are registered, so they show the record on the first
//   DRIVE cycle.
// - The record is held for exactly HOLD_CYCLES cycles.
// - Then -> GAP: config_addr=IDLE_ADDR, config_data holds its last value,
//   word_count += 1 (saturating).
// State GAP
// - in_ready=0.
// - After GAP_CYCLES cycles at IDLE_ADDR -> LOAD.
// - Latency from the 8th byte transfer to the address appearing on the bus: 1 cycle.
// - Best-case record period: 8 + HOLD_CYCLES + GAP_CYCLES cycles.
// State DONE
// - in_ready=0, done=1, busy=0, bus at IDLE_ADDR.
// - start -> LOAD with the counters cleared.
// Busy
// - busy = state is LOAD, DRIVE or GAP.
// Boundary conditions
// - start while busy: treated as an abort-restart. Partial bytes are discarded, the bus goes to
//   IDLE_ADDR next cycle, word_count=0, state=LOAD. A record mid-DRIVE is truncated.
// - start coinciding with the 8th byte transfer: start wins and the byte is discarded.
// - start in OFF with in_valid high: no transfer that cycle, because in_ready is still 0.
// - Reset mid-record: everything returns to the reset values immediately and asynchronously.
//   No partial record is ever driven.
// - EOS_ADDR is never presented on config_addr.
// - A record whose addr==IDLE_ADDR is still driven for HOLD_CYCLES and counted.
// STRUCTURE
// - Shared package cfg_bus_pkg:
//   - localparams CFG_ADDR_W=32, CFG_DATA_W=32, TILE_ID_W=16, MOD_ID_LSB=16.
//   - Loader state encoding OFF/LOAD/DRIVE/GAP/DONE.
//   - IDLE_ADDR/EOS_ADDR defaults.
// - Natural sub-module: cfg_byte_assembler. It holds byte_cnt plus the 64-bit assembly register
//   and emits rec_valid/rec_addr/rec_data for one cycle. The FSM, hold/gap counter and
//   word_count live in config_loader.
// TESTING
// - Single record: start, stream bytes 04 00 05 00 EF BE AD DE.
//   -> config_addr=32'h0005_0004, config_data=32'hDEAD_BEEF for exactly 2 cycles, starting
//      1 cycle after the 8th byte.
//   -> then IDLE_ADDR for 1 cycle, word_count=1.
// - Back-to-back: 3 records with in_valid held high.
//   -> in_ready pattern is 8 high / 3 low, repeated.
//   -> each record is held 2 cycles; word_count=3.
// - Backpressure and stalls: random in_valid gaps inside a record.
//   -> the same addr/data is assembled and no bus activity occurs before the 8th byte.
// - EOS: one record followed by FF FF FF FF 00 00 00 00.
//   -> done=1, busy=0, word_count=1, config_addr never equals 32'hFFFF_FFFF.
// - Abort and reset: start pulsed after byte 5 of a record, then a full record.
//   -> only the full record is driven.
//   -> separately, reset dropped mid-DRIVE: config_addr=IDLE_ADDR within the same cycle, done=0.
// - Saturation: force word_count to 16'hFFFE and send 3 records -> word_count stays at 16'hFFFF.

Source files
------------

// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the tile-array configuration bus: field widths, loader states and
// the default idle/end-of-stream addresses.
package cfg_bus_pkg;

    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned TILE_ID_W  = 16;
    localparam int unsigned MOD_ID_LSB = 16;
    localparam int unsigned CFG_REC_W  = CFG_ADDR_W + CFG_DATA_W;

    // Module flag 0 in addr[31:16] matches no tile, so the bus parks here between records.
    localparam logic [CFG_ADDR_W-1:0] IDLE_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [CFG_ADDR_W-1:0] EOS_ADDR_DEFAULT  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StOff,
        StLoad,
        StDrive,
        StGap,
        StDone
    } loader_state_e;

endpackage

// File: rtl/cfg_byte_assembler.sv
// Collects eight little-endian bytes into one address/data record and flags the completing
// transfer combinationally so the loader can register the record on that same edge.
module cfg_byte_assembler
    import cfg_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            in_byte,
    output logic                  rec_valid,
    output logic [CFG_ADDR_W-1:0] rec_addr,
    output logic [CFG_DATA_W-1:0] rec_data
);

    logic [2:0]           byte_cnt_q, byte_cnt_d;
    logic [CFG_REC_W-1:0] asm_q, asm_d;
    logic [CFG_REC_W-1:0] rec_full;

    always_comb begin
        // New bytes enter at the top, so after eight shifts byte 0 sits in bits [7:0].
        rec_full   = {in_byte, asm_q[CFG_REC_W-1:8]};
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        if (clear) begin
            byte_cnt_d = 3'd0;
        end else if (byte_en) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            asm_d      = rec_full;
        end
        rec_valid = byte_en && !clear && (byte_cnt_q == 3'd7);
        rec_addr  = rec_full[CFG_ADDR_W-1:0];
        rec_data  = rec_full[CFG_REC_W-1:CFG_ADDR_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= 3'd0;
            asm_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

endmodule

// File: rtl/config_loader.sv
// Byte-serial configuration loader: assembles 8-byte records and broadcasts each one to all
// tiles for a fixed hold window, followed by a gap at the idle address.
module config_loader
    import cfg_bus_pkg::*;
#(
    parameter int unsigned            HOLD_CYCLES = 2,
    parameter int unsigned            GAP_CYCLES  = 1,
    parameter logic [CFG_ADDR_W-1:0]  IDLE_ADDR   = IDLE_ADDR_DEFAULT,
    parameter logic [CFG_ADDR_W-1:0]  EOS_ADDR    = EOS_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CFG_ADDR_W-1:0] config_addr,
    output logic [CFG_DATA_W-1:0] config_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           word_count
);

    localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

    loader_state_e         state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CFG_ADDR_W-1:0] config_addr_q, config_addr_d;
    logic [CFG_DATA_W-1:0] config_data_q, config_data_d;
    logic [15:0]           word_count_q, word_count_d;

    logic                  byte_en;
    logic                  rec_valid;
    logic [CFG_ADDR_W-1:0] rec_addr;
    logic [CFG_DATA_W-1:0] rec_data;

    assign in_ready    = (state_q == StLoad);
    assign busy        = (state_q == StLoad) || (state_q == StDrive) || (state_q == StGap);
    assign done        = (state_q == StDone);
    assign config_addr = config_addr_q;
    assign config_data = config_data_q;
    assign word_count  = word_count_q;

    // A start pulse discards whatever byte arrives with it.
    assign byte_en = in_valid && in_ready && !start;

    cfg_byte_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .byte_en   (byte_en),
        .in_byte   (in_byte),
        .rec_valid (rec_valid),
        .rec_addr  (rec_addr),
        .rec_data  (rec_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        config_addr_d = config_addr_q;
        config_data_d = config_data_q;
        word_count_d  = word_count_q;
        if (start) begin
            state_d       = StLoad;
            cnt_d         = '0;
            config_addr_d = IDLE_ADDR;
            word_count_d  = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (rec_valid) begin
                        if (rec_addr == EOS_ADDR) begin
                            state_d = StDone;
                        end else begin
                            state_d       = StDrive;
                            cnt_d         = HoldLoad;
                            config_addr_d = rec_addr;
                            config_data_d = rec_data;
                        end
                    end
                end
                StDrive: begin
                    if (cnt_q == '0) begin
                        state_d       = StGap;
                        cnt_d         = GapLoad;
                        config_addr_d = IDLE_ADDR;
                        if (word_count_q != 16'hFFFF) begin
                            word_count_d = word_count_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StOff, StDone: begin
                end
                default: begin
                    state_d       = StOff;
                    config_addr_d = IDLE_ADDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StOff;
            cnt_q         <= '0;
            config_addr_q <= IDLE_ADDR;
            config_data_q <= '0;
            word_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            config_addr_q <= config_addr_d;
            config_data_q <= config_data_d;
            word_count_q  <= word_count_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: stimulus queues expected bus records, a negedge monitor
// extracts each driven record window from the bus and compares it against the queue.
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    config_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .config_addr (config_addr),
        .config_data (config_data),
        .busy        (busy),
        .done        (done),
        .word_count  (word_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic        in_win = 1'b0;
    logic [31:0] win_a;
    logic [31:0] win_d;
    int          win_len;

    task automatic close_win();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got addr %0h data %0h len %0d, expected none",
                     win_a, win_d, win_len);
        end else begin
            e = exp_q.pop_front();
            check("rec_addr", 64'(win_a), 64'(e.addr));
            check("rec_data", 64'(win_d), 64'(e.data));
            check("rec_len", 64'(win_len), 64'(e.len));
        end
        in_win = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (in_win) close_win();
        end else begin
            checks++;
            if (config_addr === 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL eos_on_bus: got %0h, expected anything else", config_addr);
            end
            if (in_win && (config_addr !== win_a || config_data !== win_d)) close_win();
            if (in_win) begin
                win_len++;
            end else if (config_addr !== 32'h0) begin
                in_win  = 1'b1;
                win_a   = config_addr;
                win_d   = config_data;
                win_len = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [31:0] a, input logic [31:0] d, input int len);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t        = 0;
        in_byte  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input int nbytes,
                            input bit stall);
        logic [63:0] r;
        int          g;
        r = {d, a};
        for (int i = 0; i < nbytes; i++) begin
            if (stall) begin
                g = int'($urandom_range(0, 3));
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            send_byte(r[i*8 +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_load();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_load_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    logic [32:0] rdy;
    logic [32:0] exp_rdy;
    logic [15:0] exp_wc;

    initial begin
        #3 reset = 1'b0;
        #9;
        check("rst_addr", 64'(config_addr), 64'h0);
        check("rst_data", 64'(config_data), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_word_count", 64'(word_count), 64'h0);
        #5 reset = 1'b1;
        @(posedge clk);
        #1;

        // Start from OFF with a byte already offered: that byte must not be taken.
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        pulse_start();
        in_valid = 1'b0;
        check("armed_busy", 64'(busy), 64'h1);

        // Single record 04 00 05 00 EF BE AD DE.
        push(32'h0005_0004, 32'hDEAD_BEEF, 2);
        send_rec(32'h0005_0004, 32'hDEAD_BEEF, 8, 1'b0);
        check("latency_addr", 64'(config_addr), 64'h0005_0004);
        check("latency_data", 64'(config_data), 64'hDEAD_BEEF);
        check("drive_in_ready", 64'(in_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("gap_addr", 64'(config_addr), 64'h0);
        check("gap_data_hold", 64'(config_data), 64'hDEAD_BEEF);
        check("single_word_count", 64'(word_count), 64'h1);
        @(posedge clk);
        #1;

        // Back-to-back records with in_valid held high: in_ready 8 high / 3 low.
        pulse_start();
        push(32'h1111_0001, 32'hAAAA_0001, 2);
        push(32'h2222_0002, 32'hAAAA_0002, 2);
        push(32'h3333_0003, 32'hAAAA_0003, 2);
        for (int i = 0; i < 33; i++) exp_rdy[i] = ((i % 11) < 8);
        fork
            begin
                for (int i = 0; i < 33; i++) begin
                    @(negedge clk);
                    rdy[i] = in_ready;
                end
            end
            begin
                send_rec(32'h1111_0001, 32'hAAAA_0001, 8, 1'b0);
                send_rec(32'h2222_0002, 32'hAAAA_0002, 8, 1'b0);
                send_rec(32'h3333_0003, 32'hAAAA_0003, 8, 1'b0);
            end
        join
        check("in_ready_pattern", 64'(rdy), 64'(exp_rdy));
        check("b2b_word_count", 64'(word_count), 64'h3);
        @(posedge clk);
        #1;

        // Stalls inside a record; nothing reaches the bus before the 8th byte.
        push(32'h00A7_0042, 32'h1234_5678, 2);
        send_rec(32'h00A7_0042, 32'h1234_5678, 7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("no_early_bus", 64'(config_addr), 64'h0);
        send_byte(8'h12);
        check("stall_addr", 64'(config_addr), 64'h00A7_0042);
        wait_load();

        // End of stream.
        pulse_start();
        push(32'h0001_0009, 32'h0BAD_F00D, 2);
        send_rec(32'h0001_0009, 32'h0BAD_F00D, 8, 1'b0);
        send_rec(32'hFFFF_FFFF, 32'h0000_0000, 8, 1'b0);
        check("eos_done", 64'(done), 64'h1);
        check("eos_busy", 64'(busy), 64'h0);
        check("eos_word_count", 64'(word_count), 64'h1);
        check("eos_addr", 64'(config_addr), 64'h0);
        check("eos_in_ready", 64'(in_ready), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", 64'(done), 64'h1);

        // Abort after byte 5, then a full record.
        pulse_start();
        check("restart_done", 64'(done), 64'h0);
        check("restart_word_count", 64'(word_count), 64'h0);
        send_rec(32'h0BAD_0BAD, 32'h0BAD_0BAD, 5, 1'b0);
        pulse_start();
        push(32'h0002_0005, 32'hCAFE_0001, 2);
        send_rec(32'h0002_0005, 32'hCAFE_0001, 8, 1'b0);
        wait_load();
        check("abort_word_count", 64'(word_count), 64'h1);

        // Start coinciding with the 8th byte discards the record.
        send_rec(32'h0003_0003, 32'h5555_5555, 7, 1'b0);
        in_byte  = 8'h55;
        in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        check("start8_word_count", 64'(word_count), 64'h0);
        check("start8_busy", 64'(busy), 64'h1);
        check("start8_addr", 64'(config_addr), 64'h0);
        push(32'h0004_0007, 32'hCAFE_0002, 2);
        send_rec(32'h0004_0007, 32'hCAFE_0002, 8, 1'b0);
        wait_load();
        check("start8_after_word_count", 64'(word_count), 64'h1);

        // Reset dropped during the first DRIVE cycle truncates the record.
        push(32'h0005_0006, 32'hFACE_0003, 1);
        send_rec(32'h0005_0006, 32'hFACE_0003, 8, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_addr", 64'(config_addr), 64'h0);
        check("rst_mid_data", 64'(config_data), 64'h0);
        check("rst_mid_done", 64'(done), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_word_count", 64'(word_count), 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Saturation from 16'hFFFE.
        pulse_start();
        force dut.word_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.word_count_q;
        exp_wc = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            push(32'h0006_0000 + 32'(k), 32'h5A5A_0000 + 32'(k), 2);
            send_rec(32'h0006_0000 + 32'(k), 32'h5A5A_0000 + 32'(k), 8, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            exp_wc = (exp_wc == 16'hFFFF) ? 16'hFFFF : exp_wc + 16'd1;
            check("sat_word_count", 64'(word_count), 64'(exp_wc));
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
